// File: rtl/datapath.sv
// Bus-based 32-bit CPU datapath: register file, PC/IR/MAR/MDR/Y, 64-bit Z
// and a combinational ALU joined by a single shared bus.
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] R_rd,
    input  logic [15:0] R_wrt,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        Zhi_out,
    input  logic        Zlo_out,
    input  logic        PC_out,
    input  logic        MDR_out,
    input  logic        MAR_out,
    input  logic        In_out,
    input  logic        C_out,
    input  logic        MAR_rd,
    input  logic        PC_rd,
    input  logic        MDR_rd,
    input  logic        IR_rd,
    input  logic        Y_rd,
    input  logic        Zlo_rd,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  op_sel,
    input  logic [31:0] Mdatain,
    output logic [31:0] r3_view,
    output logic [31:0] r4_view,
    output logic [31:0] r7_view,
    output logic [31:0] Y_view,
    output logic [31:0] Zlo_view,
    output logic [31:0] MDR_view,
    output logic [31:0] PC_view,
    output logic [31:0] BusMuxOut,
    output logic [31:0] Data_view
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_MUL  = 5'b01100,
        OP_DIV  = 5'b01101,
        OP_NEG  = 5'b01110,
        OP_NOT  = 5'b01111
    } alu_op_e;

    // Input port and constant unit are placeholders until they get real sources.
    localparam logic [31:0] IN_PORT_VAL = 32'h0;
    localparam logic [31:0] C_SIGN_VAL  = 32'h0;

    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] y_q, y_d;
    logic [31:0] zhi_q, zhi_d;
    logic [31:0] zlo_q, zlo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] bus;
    logic        bus_hit;
    logic [31:0] mdr_mux;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;

    // Shared bus: lowest-numbered GPR wins, then the special registers in order.
    always_comb begin
        bus     = 32'h0;
        bus_hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!bus_hit && R_wrt[i]) begin
                bus     = r_q[i];
                bus_hit = 1'b1;
            end
        end
        if (!bus_hit) begin
            if (HI_out)       bus = hi_q;
            else if (LO_out)  bus = lo_q;
            else if (Zhi_out) bus = zhi_q;
            else if (Zlo_out) bus = zlo_q;
            else if (PC_out)  bus = pc_q;
            else if (MDR_out) bus = mdr_q;
            else if (MAR_out) bus = mar_q;
            else if (In_out)  bus = IN_PORT_VAL;
            else if (C_out)   bus = C_SIGN_VAL;
            else              bus = 32'h0;
        end
    end

    // MDR source select: memory data or the bus.
    always_comb begin
        mdr_mux = Read ? Mdatain : bus;
    end

    logic [4:0]         sh_amt;
    logic [63:0]        rot_r;
    logic [63:0]        rot_l;
    logic signed [63:0] prod;
    logic [31:0]        div_b;
    logic signed [31:0] quo;
    logic signed [31:0] rem;

    // Operand-derived helpers; the divisor is forced non-zero to keep it defined.
    always_comb begin
        sh_amt = bus[4:0];
        rot_r  = {y_q, y_q} >> sh_amt;
        rot_l  = {y_q, y_q} << sh_amt;
        prod   = 64'($signed(y_q)) * 64'($signed(bus));
        div_b  = (bus == 32'h0) ? 32'h1 : bus;
        quo    = $signed(y_q) / $signed(div_b);
        rem    = $signed(y_q) % $signed(div_b);
    end

    // ALU with A = Y and B = bus; only MUL and DIV produce a high word.
    always_comb begin
        alu_hi = 32'h0;
        alu_lo = 32'h0;
        case (op_sel)
            OP_ADD:  alu_lo = y_q + bus;
            OP_SUB:  alu_lo = y_q - bus;
            OP_AND:  alu_lo = y_q & bus;
            OP_OR:   alu_lo = y_q | bus;
            OP_ROR:  alu_lo = rot_r[31:0];
            OP_ROL:  alu_lo = rot_l[63:32];
            OP_SHR:  alu_lo = y_q >> sh_amt;
            OP_SHRA: alu_lo = $signed(y_q) >>> sh_amt;
            OP_SHL:  alu_lo = y_q << sh_amt;
            OP_MUL: begin
                alu_hi = prod[63:32];
                alu_lo = prod[31:0];
            end
            OP_DIV: begin
                if (bus != 32'h0) begin
                    alu_hi = rem;
                    alu_lo = quo;
                end
            end
            OP_NEG:  alu_lo = 32'h0 - bus;
            OP_NOT:  alu_lo = ~bus;
            default: begin
                alu_hi = 32'h0;
                alu_lo = 32'h0;
            end
        endcase
    end

    // Next-state for every register from its load strobe.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = R_rd[i] ? bus : r_q[i];
        end
        if (PC_rd)      pc_d = bus;
        else if (IncPC) pc_d = pc_q + 32'h1;
        else            pc_d = pc_q;
        ir_d  = IR_rd  ? bus     : ir_q;
        mar_d = MAR_rd ? bus     : mar_q;
        mdr_d = MDR_rd ? mdr_mux : mdr_q;
        y_d   = Y_rd   ? bus     : y_q;
        zhi_d = Zlo_rd ? alu_hi  : zhi_q;
        zlo_d = Zlo_rd ? alu_lo  : zlo_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
    end

    // State update; clr clears everything immediately and blocks edges.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= 32'h0;
            end
            pc_q  <= 32'h0;
            ir_q  <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            y_q   <= 32'h0;
            zhi_q <= 32'h0;
            zlo_q <= 32'h0;
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= r_d[i];
            end
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Debug views and bus taps.
    always_comb begin
        r3_view   = r_q[3];
        r4_view   = r_q[4];
        r7_view   = r_q[7];
        Y_view    = y_q;
        Zlo_view  = zlo_q;
        MDR_view  = mdr_q;
        PC_view   = pc_q;
        BusMuxOut = bus;
        Data_view = mdr_mux;
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: register transfers, ALU ops, bus priority
// and asynchronous clear.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] R_rd, R_wrt;
    logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out;
    logic        MDR_out, MAR_out, In_out, C_out;
    logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd;
    logic        IncPC, Read;
    logic [4:0]  op_sel;
    logic [31:0] Mdatain;
    logic [31:0] r3_view, r4_view, r7_view, Y_view, Zlo_view;
    logic [31:0] MDR_view, PC_view, BusMuxOut, Data_view;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
        .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out),
        .Zlo_out(Zlo_out), .PC_out(PC_out), .MDR_out(MDR_out),
        .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
        .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
        .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .IncPC(IncPC), .Read(Read),
        .op_sel(op_sel), .Mdatain(Mdatain),
        .r3_view(r3_view), .r4_view(r4_view), .r7_view(r7_view),
        .Y_view(Y_view), .Zlo_view(Zlo_view), .MDR_view(MDR_view),
        .PC_view(PC_view), .BusMuxOut(BusMuxOut), .Data_view(Data_view)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        R_rd = '0; R_wrt = '0;
        HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
        MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
        MAR_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
        Zlo_rd = 0; IncPC = 0; Read = 0; op_sel = '0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; Read = 1; MDR_rd = 1;
        tick();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        mdr_load(v);
        MDR_out = 1; R_rd[idx] = 1;
        tick();
    endtask

    task automatic alu_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op);
        mdr_load(a);
        MDR_out = 1; Y_rd = 1;
        tick();
        mdr_load(b);
        MDR_out = 1; op_sel = op; Zlo_rd = 1;
        tick();
    endtask

    task automatic check_z(input string tag, input logic [31:0] hi,
                           input logic [31:0] lo);
        check({tag, "_lo"}, Zlo_view, lo);
        Zhi_out = 1;
        #1;
        check({tag, "_hi"}, BusMuxOut, hi);
        Zhi_out = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r3"}, r3_view, 32'h0);
        check({tag, "_r4"}, r4_view, 32'h0);
        check({tag, "_r7"}, r7_view, 32'h0);
        check({tag, "_y"}, Y_view, 32'h0);
        check({tag, "_zlo"}, Zlo_view, 32'h0);
        check({tag, "_mdr"}, MDR_view, 32'h0);
        check({tag, "_pc"}, PC_view, 32'h0);
        check({tag, "_bus"}, BusMuxOut, 32'h0);
    endtask

    initial begin
        idle();
        clr = 1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        clr = 0;

        // SHRA sequence
        load_reg(3, 32'hF0000096);
        load_reg(4, 32'h00000014);
        load_reg(7, 32'h00000004);
        check("ld_r3", r3_view, 32'hF0000096);
        check("ld_r4", r4_view, 32'h00000014);
        check("ld_r7", r7_view, 32'h00000004);
        R_wrt[3] = 1; Y_rd = 1;
        tick();
        check("shra_y", Y_view, 32'hF0000096);
        R_wrt[7] = 1; op_sel = 5'b01010; Zlo_rd = 1;
        #1;
        check("shra_b", BusMuxOut, 32'h00000004);
        tick();
        check("shra_z", Zlo_view, 32'hFF000009);
        Zlo_out = 1; R_rd[4] = 1;
        tick();
        check("shra_r4", r4_view, 32'hFF000009);
        check("shra_y2", Y_view, 32'hF0000096);

        // Bus idle, priority, MDR mux
        #1;
        check("bus_idle", BusMuxOut, 32'h0);
        R_wrt[3] = 1; MDR_out = 1;
        #1;
        check("prio_r3_mdr", BusMuxOut, 32'hF0000096);
        R_wrt[7] = 1;
        #1;
        check("prio_r3_r7", BusMuxOut, 32'hF0000096);
        Read = 0;
        #1;
        check("data_bus", Data_view, 32'hF0000096);
        Read = 1; Mdatain = 32'h12345678;
        #1;
        check("data_mem", Data_view, 32'h12345678);
        idle();
        R_wrt[7] = 1; R_rd[7] = 1;
        tick();
        check("self_xfer", r7_view, 32'h00000004);

        // PC
        mdr_load(32'h4);
        check("mdr4", MDR_view, 32'h4);
        MDR_out = 1; PC_rd = 1;
        tick();
        check("pc_load", PC_view, 32'h4);
        IncPC = 1;
        tick();
        check("pc_inc", PC_view, 32'h5);
        mdr_load(32'h100);
        MDR_out = 1; PC_rd = 1; IncPC = 1;
        tick();
        check("pc_rd_wins", PC_view, 32'h100);
        mdr_load(32'hFFFFFFFF);
        MDR_out = 1; PC_rd = 1;
        tick();
        IncPC = 1;
        tick();
        check("pc_wrap", PC_view, 32'h0);

        // ALU
        alu_run(32'd7, 32'd5, 5'b00011);
        check_z("add", 32'h0, 32'd12);
        alu_run(32'd7, 32'd5, 5'b00100);
        check_z("sub", 32'h0, 32'd2);
        alu_run(32'd5, 32'd7, 5'b00100);
        check_z("sub_neg", 32'h0, 32'hFFFFFFFE);
        alu_run(32'hFFFFFFFE, 32'd3, 5'b01100);
        check_z("mul", 32'hFFFFFFFF, 32'hFFFFFFFA);
        alu_run(32'd7, 32'd2, 5'b01101);
        check_z("div", 32'd1, 32'd3);
        alu_run(32'hFFFFFFF9, 32'd2, 5'b01101);
        check_z("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        alu_run(32'd7, 32'd0, 5'b01101);
        check_z("div0", 32'h0, 32'h0);
        alu_run(32'h0000000F, 32'h0000003C, 5'b00101);
        check_z("and", 32'h0, 32'h0000000C);
        alu_run(32'h0000000F, 32'h000000F0, 5'b00110);
        check_z("or", 32'h0, 32'h000000FF);
        alu_run(32'h00000011, 32'd4, 5'b00111);
        check_z("ror", 32'h0, 32'h10000001);
        alu_run(32'h80000001, 32'd1, 5'b01000);
        check_z("rol", 32'h0, 32'h00000003);
        alu_run(32'h80000000, 32'd4, 5'b01001);
        check_z("shr", 32'h0, 32'h08000000);
        alu_run(32'h00000003, 32'd4, 5'b01011);
        check_z("shl", 32'h0, 32'h00000030);
        alu_run(32'h12345678, 32'd5, 5'b01110);
        check_z("neg", 32'h0, 32'hFFFFFFFB);
        alu_run(32'h12345678, 32'h0F0F0F0F, 5'b01111);
        check_z("not", 32'h0, 32'hF0F0F0F0);
        alu_run(32'h12345678, 32'd5, 5'b11111);
        check_z("undef_op", 32'h0, 32'h0);

        // Async clear mid-cycle with a pending load
        load_reg(3, 32'hA5A5A5A5);
        mdr_load(32'h77);
        MDR_out = 1; PC_rd = 1;
        tick();
        check("pre_clr_pc", PC_view, 32'h77);
        #2;
        R_rd[3] = 1; MDR_out = 1; Y_rd = 1;
        Mdatain = 32'hDEADBEEF; Read = 1; MDR_rd = 1;
        clr = 1;
        #1;
        idle();
        check_all_zero("clr_async");
        MDR_out = 1; R_rd[3] = 1; IncPC = 1;
        Mdatain = 32'hDEADBEEF; Read = 1; MDR_rd = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle();
        check_all_zero("clr_held");
        @(negedge clk);
        clr = 0;
        IncPC = 1;
        tick();
        check("post_clr_pc", PC_view, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
